riscv_fetch_unit: RTL and testbench
===================================

Name: riscv_fetch_unit

Overview:
Parametrised instruction fetch stage for the next-generation core. It replaces the single PC register and mux with a PC generator, a prefetch queue and a valid/ready handshake toward decode. It issues sequential fetches to instruction memory with fixed one-cycle read latency, buffers the returned instructions with their PC, and handles control-flow redirects by flushing the queue and dropping in-flight responses. It sits between the control/branch logic (redirect source), imem, and the decode/regfile stage.

Parameters:
XLEN, 32, datapath and PC width
DEPTH, 4, prefetch queue entries; power of two, >= 2
RESET_PC, 32'h0000_0000, first fetch address after reset (word-aligned)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-low (asserted at 0)
redirect_i  in  1  branch/jump taken; flush and restart fetch
redirect_pc_i  in  XLEN  new fetch address; bits [1:0] ignored (forced 0)
imem_req_o  out  1  fetch request valid
imem_addr_o  out  XLEN  fetch address, word-aligned
imem_ready_i  in  1  imem accepts request this cycle
imem_rdata_i  in  32  instruction; valid exactly 1 cycle after an accepted request
inst_valid_o  out  1  queue head valid toward decode
inst_ready_i  in  1  decode consumes head
inst_o  out  32  head instruction; NOP 32'h0000_0013 when not valid
pc_o  out  XLEN  PC of head instruction
pc_4_o  out  XLEN  pc_o + 4, for link/writeback
count_o  out  $clog2(DEPTH)+1  queue occupancy

Behaviour:
- Reset (rst=0, asynchronous): state=BOOT, fetch_pc=RESET_PC, queue empty, in-flight flag cleared; outputs: imem_req_o=0, imem_addr_o=RESET_PC, inst_valid_o=0, inst_o=NOP, pc_o=0, pc_4_o=4, count_o=0. Reset mid-operation discards everything; no partial state survives.
- FSM: BOOT -> RUN (unconditionally, one cycle after reset release). RUN: redirect_i=1 -> REDIR, otherwise stay. REDIR -> RUN unconditionally (one cycle). Redirect while in REDIR restarts REDIR with the new PC.
- Request issue (RUN only): imem_req_o=1 when count + inflight < DEPTH; imem_addr_o=fetch_pc. Acceptance = imem_req_o & imem_ready_i; on acceptance fetch_pc += 4 (wraps modulo 2^XLEN) and inflight=1 for the next cycle, otherwise inflight=0. If not accepted, request and address held stable. At most one outstanding request.
- Response: in the cycle after acceptance, {imem_rdata_i, issued PC} is pushed into the queue, unless state is REDIR or redirect_i=1 in that cycle, in which case it is discarded.
- Decode handshake: pop when inst_valid_o & inst_ready_i. inst_o/pc_o come straight from the queue head (no extra latency). Push and pop in the same cycle leave count unchanged. Pop on empty is ignored. Overflow is impossible by credit rule; an assertion flags push-when-full.
- Redirect (highest priority): in the cycle redirect_i=1, the queue is cleared (count_o=0 next cycle), any pop/push that cycle is void, fetch_pc <= {redirect_pc_i[XLEN-1:2],2'b00}, state -> REDIR. A request may still be accepted in the redirect cycle; its response lands in REDIR and is dropped. The first request to the new PC is issued in the cycle after REDIR (2 cycles after redirect_i), and the first valid instruction appears 1 cycle later.
- Latency: the fetch request at cycle t produces inst_valid_o at t+1 when the queue is empty. Sustained throughput is 1 instr/cycle with imem_ready_i=1 and inst_ready_i=1.

Decomposition:
- Shared package riscv_pkg: XLEN default, RISCV_NOP constant (32'h0000_0013), fetch_state_t enum {BOOT, RUN, REDIR}.
- One sub-module: riscv_fetch_fifo: synchronous FIFO, parametrised DEPTH and WIDTH (here 32+XLEN), with flush input, count output and async active-low reset.

Test Plan:
- Reset release, RESET_PC=0, imem returns addr-derived data, inst_ready_i=1: first request at addr 0x0 in the 2nd cycle; inst_valid_o then stays high with pc_o 0x0, 0x4, 0x8 on consecutive cycles; pc_4_o = pc_o+4.
- inst_ready_i=0 held, DEPTH=4: exactly 4 requests accepted, count_o reaches 4, imem_req_o drops to 0; raise ready: head pc_o=0x0, fetching resumes with no loss or duplication.
- imem_ready_i=0 for 3 cycles at addr 0x8: imem_req_o=1, imem_addr_o=0x8 stable all 3 cycles; after acceptance the next address is 0xC.
- redirect_i=1 with redirect_pc_i=0x100 while count=3 and a request is in flight: next cycle count_o=0, inst_valid_o=0; the in-flight response is dropped; imem_addr_o=0x100 two cycles after redirect; the first delivered pc_o=0x100.
- Redirect to 0x203 and back-to-back redirects (0x40 then 0x80 in consecutive cycles): fetch starts at 0x200 and 0x80 respectively; no instruction from 0x40 is ever delivered.
- fetch_pc at 0xFFFF_FFFC: next request address wraps to 0x0; rst asserted mid-stream: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch stage: default datapath width,
// the canonical NOP encoding and the fetch FSM state type.
package riscv_pkg;

  localparam int          DEFAULT_XLEN = 32;
  localparam logic [31:0] RISCV_NOP    = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    REDIR
  } fetch_state_t;

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Prefetch queue with fall-through read: a push into an empty queue is visible
// at the head in the same cycle, so fetch-to-decode latency stays at one cycle.
module riscv_fetch_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             empty;
  logic             full;
  logic             do_write;
  logic             do_read;

  // A push that is consumed straight through the bypass is never stored.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    rd_valid = ~empty | push;
    rd_data  = empty ? wr_data : mem[rd_ptr_q];
    do_write = push & ~flush & ~(empty & pop);
    do_read  = pop & ~flush & ~empty;
  end

  // NOTE: storage is not reset; the pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_write) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_read) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_write, do_read})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign count = count_q;

  // The fetch credit scheme must never let a response arrive with no room.
  no_push_when_full : assert property (
    @(posedge clk) disable iff (!rst_n) (push && !flush) |-> !full
  );

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: PC generator, single-outstanding imem requests,
// prefetch queue and valid/ready delivery to decode, with redirect flush.
module riscv_fetch_unit
  import riscv_pkg::*;
#(
  parameter  int              XLEN     = DEFAULT_XLEN,
  parameter  int              DEPTH    = 4,
  parameter  logic [XLEN-1:0] RESET_PC = '0,
  localparam int              CW       = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ready_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_4_o,
  output logic [CW-1:0]   count_o
);

  localparam int EW = 32 + XLEN;

  fetch_state_t    state_q;
  fetch_state_t    state_d;
  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] issued_pc_q;
  logic            inflight_q;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   credits_used;
  logic            accept;
  logic            push;
  logic            pop;
  logic            head_valid;
  logic [EW-1:0]   head_entry;

  // An in-flight request already owns a queue slot, so it counts as a credit.
  always_comb begin
    state_d      = state_q;
    credits_used = fifo_count + CW'(inflight_q);
    imem_req_o   = 1'b0;
    unique case (state_q)
      BOOT:  state_d = RUN;
      RUN: begin
        imem_req_o = (credits_used < CW'(DEPTH));
        if (redirect_i) begin
          state_d = REDIR;
        end
      end
      REDIR: state_d = redirect_i ? REDIR : RUN;
      default: state_d = BOOT;
    endcase
  end

  assign accept      = imem_req_o & imem_ready_i;
  assign imem_addr_o = fetch_pc_q;

  // Responses landing in REDIR or during a redirect belong to the old path.
  assign push = inflight_q & (state_q != REDIR) & ~redirect_i;
  assign pop  = head_valid & inst_ready_i & ~redirect_i;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= BOOT;
      fetch_pc_q  <= RESET_PC;
      issued_pc_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= accept;
      if (accept) begin
        issued_pc_q <= fetch_pc_q;
      end
      if (redirect_i) begin
        fetch_pc_q <= redirect_pc_i & ~XLEN'(3);
      end else if (accept) begin
        fetch_pc_q <= fetch_pc_q + XLEN'(4);
      end
    end
  end

  riscv_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .flush    (redirect_i),
    .push     (push),
    .wr_data  ({imem_rdata_i, issued_pc_q}),
    .pop      (pop),
    .rd_valid (head_valid),
    .rd_data  (head_entry),
    .count    (fifo_count)
  );

  always_comb begin
    inst_valid_o = head_valid;
    inst_o       = RISCV_NOP;
    pc_o         = '0;
    if (head_valid) begin
      inst_o = head_entry[EW-1 -: 32];
      pc_o   = head_entry[XLEN-1:0];
    end
  end

  assign pc_4_o  = pc_o + XLEN'(4);
  assign count_o = fifo_count;

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Directed bench for riscv_fetch_unit: one-cycle imem responder returning
// address-derived instructions, hand-computed expected PCs and queue counts.
module tb_riscv_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic [31:0] pc_4_o;
  logic [2:0]  count_o;

  int n_cmp   = 0;
  int n_bad   = 0;
  int acc_cnt = 0;
  bit watch_40 = 1'b0;
  bit seen_40  = 1'b0;

  riscv_fetch_unit #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ready_i  (imem_ready_i),
    .imem_rdata_i  (imem_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_ready_i  (inst_ready_i),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .pc_4_o        (pc_4_o),
    .count_o       (count_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] addr);
    return addr ^ 32'hDEAD_0000;
  endfunction

  // imem: data valid exactly one cycle after an accepted request
  always @(posedge clk)
    imem_rdata_i <= (imem_req_o && imem_ready_i) ? inst_of(imem_addr_o) : 32'hBAD0_BAD0;

  always @(posedge clk)
    if (!rst) acc_cnt <= 0;
    else if (imem_req_o && imem_ready_i) acc_cnt <= acc_cnt + 1;

  always @(posedge clk)
    if (watch_40 && inst_valid_o && inst_ready_i && !redirect_i && pc_o == 32'h40)
      seen_40 <= 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req"},   64'(imem_req_o),   64'd0);
    check({tag, "_addr"},  64'(imem_addr_o),  64'h0);
    check({tag, "_valid"}, 64'(inst_valid_o), 64'd0);
    check({tag, "_inst"},  64'(inst_o),       64'h13);
    check({tag, "_pc"},    64'(pc_o),         64'h0);
    check({tag, "_pc4"},   64'(pc_4_o),       64'h4);
    check({tag, "_count"}, 64'(count_o),      64'd0);
  endtask

  // Leaves the bench one cycle into BOOT after reset release.
  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst           = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    imem_ready_i  = 1'b1;
    inst_ready_i  = 1'b1;

    // Reset state and first sequential fetches
    tick();
    tick();
    check_reset("rst");
    rst = 1'b1;
    check("boot_req", 64'(imem_req_o), 64'd0);
    tick();
    check("first_req",  64'(imem_req_o),   64'd1);
    check("first_addr", 64'(imem_addr_o),  64'h0);
    check("first_nv",   64'(inst_valid_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("seq_valid", 64'(inst_valid_o), 64'd1);
      check("seq_pc",    64'(pc_o),   64'(32'(4 * i)));
      check("seq_inst",  64'(inst_o), 64'(inst_of(32'(4 * i))));
      check("seq_pc4",   64'(pc_4_o), 64'(32'(4 * i + 4)));
    end
    check("seq_count", 64'(count_o), 64'd0);

    // Decode stalled: queue fills to DEPTH, then drains in order
    inst_ready_i = 1'b0;
    do_reset();
    repeat (8) tick();
    check("full_acc",   64'(acc_cnt),      64'd4);
    check("full_count", 64'(count_o),      64'd4);
    check("full_req",   64'(imem_req_o),   64'd0);
    check("full_head",  64'(pc_o),         64'h0);
    inst_ready_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("drain_pc",   64'(pc_o),   64'(32'(4 * i)));
      check("drain_inst", 64'(inst_o), 64'(inst_of(32'(4 * i))));
    end

    // imem back-pressure at 0x8
    do_reset();
    tick();
    tick();
    tick();
    imem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_req",  64'(imem_req_o),  64'd1);
      check("stall_addr", 64'(imem_addr_o), 64'h8);
      tick();
    end
    imem_ready_i = 1'b1;
    check("stall_nv",   64'(inst_valid_o), 64'd0);
    check("stall_hold", 64'(imem_addr_o),  64'h8);
    tick();
    check("stall_next", 64'(imem_addr_o), 64'hC);
    check("stall_pc",   64'(pc_o),        64'h8);

    // Redirect with three queued entries and a response in flight
    inst_ready_i = 1'b0;
    do_reset();
    repeat (5) tick();
    check("pre_redir_count", 64'(count_o), 64'd3);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h100;
    tick();
    redirect_i   = 1'b0;
    inst_ready_i = 1'b1;
    check("redir_count", 64'(count_o),      64'd0);
    check("redir_nv",    64'(inst_valid_o), 64'd0);
    check("redir_req",   64'(imem_req_o),   64'd0);
    tick();
    check("redir_req2",  64'(imem_req_o),   64'd1);
    check("redir_addr",  64'(imem_addr_o),  64'h100);
    check("redir_drop",  64'(inst_valid_o), 64'd0);
    tick();
    check("redir_valid", 64'(inst_valid_o), 64'd1);
    check("redir_pc",    64'(pc_o),         64'h100);
    check("redir_inst",  64'(inst_o),       64'(inst_of(32'h100)));
    tick();
    check("redir_pc2",   64'(pc_o),         64'h104);

    // Misaligned redirect target, request accepted in the redirect cycle
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h203;
    tick();
    redirect_i = 1'b0;
    check("mis_nv",    64'(inst_valid_o), 64'd0);
    tick();
    check("mis_addr",  64'(imem_addr_o),  64'h200);
    tick();
    check("mis_pc",    64'(pc_o),         64'h200);

    // Back-to-back redirects: 0x40 is superseded by 0x80
    watch_40      = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h40;
    tick();
    redirect_pc_i = 32'h80;
    tick();
    redirect_i = 1'b0;
    check("b2b_req0",  64'(imem_req_o),  64'd0);
    tick();
    check("b2b_req",   64'(imem_req_o),  64'd1);
    check("b2b_addr",  64'(imem_addr_o), 64'h80);
    tick();
    check("b2b_pc",    64'(pc_o),        64'h80);
    tick();
    check("b2b_pc2",   64'(pc_o),        64'h84);
    check("b2b_no40",  64'(seen_40),     64'd0);

    // PC wrap at the top of the address space, then reset mid-stream
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    tick();
    check("wrap_addr", 64'(imem_addr_o), 64'hFFFF_FFFC);
    tick();
    check("wrap_next", 64'(imem_addr_o), 64'h0);
    check("wrap_pc",   64'(pc_o),        64'hFFFF_FFFC);
    check("wrap_pc4",  64'(pc_4_o),      64'h0);
    tick();
    check("wrap_pc0",  64'(pc_o),        64'h0);
    check("wrap_inst", 64'(inst_o),      64'(inst_of(32'h0)));
    rst = 1'b0;
    #1;
    check_reset("async");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
